// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two read ports, a debug read port
// and one write port.
//
// Ports:
//   clk            - clock; all state updates on the rising edge
//   rst            - asynchronous active-high reset; clears all state at once
//   RegWrite       - write enable
//   Write_Register - destination index (rd, rt or 31 for link)
//   Write_Data     - data to write
//   Read_Register1 - index for read port 1 (rs)
//   Read_Register2 - index for read port 2 (rt)
//   Read_Data1     - combinational contents of Read_Register1
//   Read_Data2     - combinational contents of Read_Register2
//   Dbg_Register   - index for the debug read port
//   Dbg_Data       - combinational contents of Dbg_Register
//   Write_Count    - committed writes since reset, wraps at 16 bits
//
// Register 0 is hardwired to zero. Reads of the register being written in the
// same cycle see Write_Data (write-through bypass). While rst is high every
// read port returns zero and bypass is suppressed.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic [4:0]  Write_Register,
  input  logic [31:0] Write_Data,
  input  logic [4:0]  Read_Register1,
  input  logic [4:0]  Read_Register2,
  output logic [31:0] Read_Data1,
  output logic [31:0] Read_Data2,
  input  logic [4:0]  Dbg_Register,
  output logic [31:0] Dbg_Data,
  output logic [15:0] Write_Count
);

  logic [31:0] regs [0:31];
  logic        commit;

  // A write only counts when it targets a real register; index 0 is discarded.
  assign commit = RegWrite && (Write_Register != 5'd0);

  // Storage update. Entry 0 is cleared by reset and never written afterwards,
  // so it stays zero; the read path also forces zero for index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (commit) begin
      regs[Write_Register] <= Write_Data;
    end
  end

  // Committed-write counter; natural 16-bit wraparound, no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Write_Count <= 16'd0;
    end else if (commit) begin
      Write_Count <= Write_Count + 16'd1;
    end
  end

  // Shared read-port behaviour: reset and index 0 win over bypass, bypass
  // wins over the stored value.
  function automatic logic [31:0] read_port(input logic [4:0] idx);
    logic [31:0] value;
    value = regs[idx];
    if (rst || (idx == 5'd0)) begin
      value = 32'd0;
    end else if (commit && (idx == Write_Register)) begin
      value = Write_Data;
    end
    return value;
  endfunction

  // Three independent combinational read ports.
  always_comb begin
    Read_Data1 = read_port(Read_Register1);
    Read_Data2 = read_port(Read_Register2);
    Dbg_Data   = read_port(Dbg_Register);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Drives a linear sequence of steps from one initial block and checks each
// observation with an immediate assertion against hand-computed values.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Register1;
  logic [4:0]  Read_Register2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [4:0]  Dbg_Register;
  logic [31:0] Dbg_Data;
  logic [15:0] Write_Count;

  int checks;
  int failures;

  reg_file dut (
    .clk            (clk),
    .rst            (rst),
    .RegWrite       (RegWrite),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Read_Register1 (Read_Register1),
    .Read_Register2 (Read_Register2),
    .Read_Data1     (Read_Data1),
    .Read_Data2     (Read_Data2),
    .Dbg_Register   (Dbg_Register),
    .Dbg_Data       (Dbg_Data),
    .Write_Count    (Write_Count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [4:0] wr,
                               input logic [31:0] wd, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] dbg);
    RegWrite       = we;
    Write_Register = wr;
    Write_Data     = wd;
    Read_Register1 = r1;
    Read_Register2 = r2;
    Dbg_Register   = dbg;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    checks   = 0;
    failures = 0;

    // Reset held: reads are zero even with a bypass-shaped write pending.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h55555555, 5'd5, 5'd5, 5'd5);
    checkOutput("rst_byp_rd1", Read_Data1, 32'd0);
    checkOutput("rst_byp_rd2", Read_Data2, 32'd0);
    checkOutput("rst_byp_dbg", Dbg_Data, 32'd0);
    tick();
    checkOutput("rst_write_ignored", Read_Data1, 32'd0);
    checkOutput("rst_count", {16'd0, Write_Count}, 32'd0);

    // Release reset; every index on every port reads zero.
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
      checkOutput($sformatf("post_rst_rd1_%0d", i), Read_Data1, 32'd0);
      checkOutput($sformatf("post_rst_rd2_%0d", i), Read_Data2, 32'd0);
      checkOutput($sformatf("post_rst_dbg_%0d", i), Dbg_Data, 32'd0);
    end
    checkOutput("post_rst_count", {16'd0, Write_Count}, 32'd0);

    // Basic write then read back.
    applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd0);
    checkOutput("wr8_rd1", Read_Data1, 32'hDEADBEEF);
    checkOutput("wr8_count", {16'd0, Write_Count}, 32'd1);

    // Write to register 0 is discarded and not counted.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_before", Read_Data1, 32'd0);
    tick();
    checkOutput("r0_after", Read_Data1, 32'd0);
    checkOutput("r0_count", {16'd0, Write_Count}, 32'd1);

    // Triple bypass on register 31.
    applyStimulus(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 5'd31);
    checkOutput("byp31_rd1", Read_Data1, 32'hCAFEF00D);
    checkOutput("byp31_rd2", Read_Data2, 32'hCAFEF00D);
    checkOutput("byp31_dbg", Dbg_Data, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 5'd31, 32'h0BADF00D, 5'd31, 5'd31, 5'd31);
    checkOutput("st31_rd1", Read_Data1, 32'hCAFEF00D);
    checkOutput("st31_rd2", Read_Data2, 32'hCAFEF00D);
    checkOutput("st31_dbg", Dbg_Data, 32'hCAFEF00D);
    checkOutput("st31_count", {16'd0, Write_Count}, 32'd2);

    // RegWrite low leaves storage and count alone.
    applyStimulus(1'b0, 5'd8, 32'h99999999, 5'd8, 5'd0, 5'd0);
    tick();
    checkOutput("nowe_rd1", Read_Data1, 32'hDEADBEEF);
    checkOutput("nowe_count", {16'd0, Write_Count}, 32'd2);

    // Mixed ports: rd1 and dbg bypassed, rd2 stored.
    applyStimulus(1'b1, 5'd8, 32'h11112222, 5'd8, 5'd31, 5'd8);
    checkOutput("mix_rd1", Read_Data1, 32'h11112222);
    checkOutput("mix_rd2", Read_Data2, 32'hCAFEF00D);
    checkOutput("mix_dbg", Dbg_Data, 32'h11112222);
    tick();
    checkOutput("mix_count", {16'd0, Write_Count}, 32'd3);

    // Fill 1..31 with index*0x01010101 and read them all back.
    for (int i = 1; i < 32; i++) begin
      v = 32'h01010101 * 32'(i);
      applyStimulus(1'b1, 5'(i), v, 5'd0, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("fill_count", {16'd0, Write_Count}, 32'd34);
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i), 5'(i));
      checkOutput($sformatf("fill_rd1_%0d", i), Read_Data1, 32'h01010101 * 32'(i));
      checkOutput($sformatf("fill_rd2_%0d", 32 - i), Read_Data2, 32'h01010101 * 32'(32 - i));
    end

    // Asynchronous reset between edges clears everything at once.
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd8, 5'd31, 5'd29);
    checkOutput("pre_arst_rd1", Read_Data1, 32'h08080808);
    rst = 1'b1;
    #1;
    checkOutput("arst_rd1", Read_Data1, 32'd0);
    checkOutput("arst_rd2", Read_Data2, 32'd0);
    checkOutput("arst_dbg", Dbg_Data, 32'd0);
    checkOutput("arst_count", {16'd0, Write_Count}, 32'd0);

    // Release mid-cycle; the write on the next edge must land.
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd8, 5'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_byp_rd1", Read_Data1, 32'hA5A5A5A5);
    checkOutput("rel_rd2_cleared", Read_Data2, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
    checkOutput("rel_st_rd1", Read_Data1, 32'hA5A5A5A5);
    checkOutput("rel_st_dbg", Dbg_Data, 32'hA5A5A5A5);
    checkOutput("rel_count", {16'd0, Write_Count}, 32'd1);

    // Counter wrap: fresh reset, then 65537 committed writes to reg 7.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      applyStimulus(1'b1, 5'd7, 32'(i), 5'd0, 5'd0, 5'd0);
      tick();
    end
    checkOutput("cnt_ffff", {16'd0, Write_Count}, 32'h0000FFFF);
    applyStimulus(1'b1, 5'd7, 32'd65536, 5'd0, 5'd0, 5'd0);
    tick();
    checkOutput("cnt_wrap0", {16'd0, Write_Count}, 32'h00000000);
    applyStimulus(1'b1, 5'd7, 32'd65537, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 5'd0);
    checkOutput("cnt_wrap1", {16'd0, Write_Count}, 32'h00000001);
    checkOutput("cnt_last_data", Read_Data1, 32'd65537);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-003 RegWrite  input  1  write enable for the write port.
REQ-004 Write_Register  input  5  destination register index, driven by the RegDst selector (rd, rt, or 31 for link).
REQ-005 Write_Data  input  32  data to be written.
REQ-006 Read_Register1  input  5  index for read port 1 (rs).
REQ-007 Read_Register2  input  5  index for read port 2 (rt).
REQ-008 Read_Data1  output  32  contents selected by Read_Register1.
REQ-009 Read_Data2  output  32  contents selected by Read_Register2.
REQ-010 Dbg_Register  input  5  index for debug read port.
REQ-011 Dbg_Data  output  32  contents selected by Dbg_Register.
REQ-012 Write_Count  output  16  number of committed writes since reset.

Function
REQ-013 Storage SHALL be 32 registers of 32 bits, indices 0-31.
REQ-014 On a rising clk edge with RegWrite=1 and Write_Register!=0, the register at Write_Register SHALL take Write_Data.
REQ-015 Writes with Write_Register=0 SHALL be discarded; register 0 SHALL always read 0.
REQ-016 Writes with RegWrite=0 SHALL leave all registers unchanged.
REQ-017 Read ports SHALL be combinational: zero-cycle latency from Read_RegisterN to Read_DataN.
REQ-018 Write-through bypass: if RegWrite=1, Write_Register!=0 and Write_Register equals a read index in the same cycle, that port SHALL output Write_Data instead of the stored value.
REQ-019 Bypass SHALL apply independently to Read_Data1, Read_Data2 and Dbg_Data; any combination may be bypassed at once.
REQ-020 A read index of 0 SHALL yield 0 regardless of bypass conditions.
REQ-021 Write_Count SHALL increment by 1 on each committed write (per REQ-014) only.
REQ-022 Write_Count SHALL wrap from 0xFFFF to 0x0000 without saturation.
REQ-023 Write_Register=31 SHALL be handled as a normal write (link register); no special path.
REQ-024 Outputs SHALL never be X once rst has been asserted at least once.

Reset
REQ-025 While rst=1, all 32 registers SHALL be 0 and Write_Count SHALL be 0; writes SHALL be ignored.
REQ-026 While rst=1, Read_Data1, Read_Data2 and Dbg_Data SHALL be 0 for every index, bypass disabled.
REQ-027 Reset asserted mid-operation SHALL clear state immediately without waiting for clk; a write on the same edge as rst deassertion SHALL not be lost if rst is low at that edge.
REQ-028 Register 29 (sp) and all others SHALL reset to 0; no non-zero reset values.

Verification
REQ-029 Assert rst, release; read all 32 indices on all three ports -> all 0; Write_Count=0.
REQ-030 Write 0xDEADBEEF to reg 8, next cycle read Read_Register1=8 -> 0xDEADBEEF; Write_Count=1.
REQ-031 RegWrite=1, Write_Register=0, Write_Data=0x12345678 -> Read_Data1 with index 0 = 0 before and after the edge; Write_Count unchanged.
REQ-032 Same cycle: write 0xCAFEF00D to reg 31 with Read_Register1=Read_Register2=Dbg_Register=31 -> all three ports show 0xCAFEF00D before the edge; stored value matches after.
REQ-033 Fill regs 1-31 with index*0x01010101, assert rst asynchronously between edges -> all reads 0 immediately, before the next clk edge.
REQ-034 Perform 65537 committed writes -> Write_Count=0x0001.
